sum_latch_uart_tx: RTL

SUM_LATCH_UART_TX -- requirements
Module: sum_latch_uart_tx

---
 rtl/sum_latch_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 104 ++++++++++
 rtl/sum_latch_uart_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sum_latch_pkg.sv
// Shared transmitter state encoding and width helpers for the summing latch UART block.
package sum_latch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_NEXT  = 3'd4
   } tx_state_e;

   function automatic int res_width(input int data_w, input int num_ops);
      return data_w + $clog2(num_ops) + 1;
   endfunction

   function automatic int byte_count(input int res_w);
      return (res_w + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser for one byte: start bit, eight data bits LSB first, stop bit.
// state    | meaning
// IDLE     | line high, waiting for start_i
// START    | driving start bit (low)
// DATA     | shifting out data bits
// STOP     | driving stop bit (high); done_o pulses on its last cycle
module uart_tx_byte
   import sum_latch_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       txd_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;
   logic             tc;

   assign tc = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      done_o  = 1'b0;
      if (state_q != ST_IDLE) begin
         cnt_d = tc ? CNT_LOAD : cnt_q - CNT_W'(1);
      end
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_START;
               cnt_d   = CNT_LOAD;
               shift_d = data_i;
               bit_d   = '0;
               txd_d   = 1'b0;
            end
         end
         ST_START: begin
            if (tc) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         ST_DATA: begin
            if (tc) begin
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_STOP: begin
            if (tc) begin
               state_d = ST_IDLE;
               done_o  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   assign txd_o  = txd_q;
   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Latches operands on synchronised button presses, adds or subtracts them, and sends the
// result over UART as little-endian bytes.
// state    | meaning
// IDLE     | waiting for a pending result and uart_tx_en
// START    | one byte in flight inside uart_tx_byte (START/DATA/STOP)
// NEXT     | one-cycle gap after a stop bit; launches the next byte or returns to IDLE
module sum_latch_uart_tx
   import sum_latch_pkg::*;
#(
   parameter  int DATA_W       = 5,
   parameter  int NUM_OPS      = 2,
   parameter  int CLKS_PER_BIT = 434,
   localparam int RES_W        = res_width(DATA_W, NUM_OPS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  data_input,
   input  logic [NUM_OPS-1:0] save_n,
   input  logic               op_sub,
   input  logic               uart_tx_en,
   output logic               uart_txd,
   output logic               uart_tx_busy,
   output logic [RES_W-1:0]   result
);

   localparam int NBYTES = byte_count(RES_W);
   localparam int EXT_W  = 8 * NBYTES;
   localparam int BCNT_W = $clog2(NBYTES + 1);

   logic [NUM_OPS-1:0] sync1_q, sync2_q, sync3_q;
   logic [NUM_OPS-1:0] save_evt;
   logic [DATA_W-1:0]  op_q [NUM_OPS];
   logic [RES_W-1:0]   result_q, result_d;
   logic [EXT_W-1:0]   ext_d;
   logic [EXT_W-1:0]   snap_q, snap_d;
   logic [BCNT_W-1:0]  left_q, left_d;
   logic               pending_q, pending_d;
   tx_state_e          seq_q, seq_d;
   logic               tx_go;
   logic               byte_start;
   logic [7:0]         byte_data;
   logic               byte_busy;
   logic               byte_done;

   // sync3_q holds the previous synchronised level so a press is seen as a falling edge
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         sync3_q <= '1;
      end else begin
         sync1_q <= save_n;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign save_evt = sync3_q & ~sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (save_evt[i]) op_q[i] <= data_input;
         end
      end
   end

   always_comb begin
      result_d = RES_W'(op_q[0]);
      for (int i = 1; i < NUM_OPS; i++) begin
         if (op_sub) result_d = result_d - RES_W'(op_q[i]);
         else        result_d = result_d + RES_W'(op_q[i]);
      end
   end

   always_comb begin
      ext_d = '0;
      ext_d[RES_W-1:0] = result_d;
      for (int i = RES_W; i < EXT_W; i++) ext_d[i] = op_sub & result_d[RES_W-1];
   end

   // Snapshot uses the combinational result so a load one edge earlier is already included
   assign tx_go = (seq_q == ST_IDLE) && pending_q && uart_tx_en;

   always_comb begin
      seq_d      = seq_q;
      snap_d     = snap_q;
      left_d     = left_q;
      byte_start = 1'b0;
      byte_data  = snap_q[7:0];
      case (seq_q)
         ST_IDLE: begin
            if (tx_go) begin
               byte_start = 1'b1;
               byte_data  = ext_d[7:0];
               snap_d     = ext_d >> 8;
               left_d     = BCNT_W'(NBYTES - 1);
               seq_d      = ST_START;
            end
         end
         ST_START: begin
            if (byte_done) seq_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (left_q != '0) begin
               byte_start = 1'b1;
               byte_data  = snap_q[7:0];
               snap_d     = snap_q >> 8;
               left_d     = left_q - BCNT_W'(1);
               seq_d      = ST_START;
            end else begin
               seq_d = ST_IDLE;
            end
         end
         default: seq_d = ST_IDLE;
      endcase
   end

   // A load on the launch edge keeps pending set: that snapshot predates the new operand
   assign pending_d = (|save_evt) ? 1'b1 : (tx_go ? 1'b0 : pending_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q  <= '0;
         pending_q <= 1'b0;
         seq_q     <= ST_IDLE;
         snap_q    <= '0;
         left_q    <= '0;
      end else begin
         result_q  <= result_d;
         pending_q <= pending_d;
         seq_q     <= seq_d;
         snap_q    <= snap_d;
         left_q    <= left_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk    (clk),
      .reset  (reset),
      .start_i(byte_start),
      .data_i (byte_data),
      .txd_o  (uart_txd),
      .busy_o (byte_busy),
      .done_o (byte_done)
   );

   assign uart_tx_busy = byte_busy || ((seq_q == ST_NEXT) && (left_q != '0));
   assign result       = result_q;

endmodule
